// File: rtl/obstacle_scheduler_pkg.sv
// Shared types and constants for the obstacle sequencer: state encoding,
// obstacle codes, counter widths and the pixel-clock frequency.
package obstacle_pkg;

    localparam int unsigned CLK_FREQ_HZ = 65000000;
    localparam int unsigned TIMER_W     = 28;
    localparam int unsigned ROUND_W     = 5;
    localparam int unsigned CODE_W      = 4;
    localparam int unsigned LFSR_W      = 16;

    localparam logic [CODE_W-1:0] NO_OBSTACLE = 4'hF;
    localparam logic [CODE_W-1:0] OBST_0      = 4'd0;
    localparam logic [CODE_W-1:0] OBST_1      = 4'd1;
    localparam logic [CODE_W-1:0] OBST_2      = 4'd2;
    localparam logic [CODE_W-1:0] OBST_3      = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_LAUNCH,
        ST_WAIT,
        ST_GAP,
        ST_OVER,
        ST_WIN
    } state_e;

    // (code + 1) mod n, evaluated wide so 4'hF + 1 does not wrap early
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                    input int unsigned n);
        return CODE_W'((32'(code) + 32'd1) % n);
    endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Bundle between game/menu logic, the obstacle bank and the scheduler.
interface obstacle_scheduler_if #(
    parameter int unsigned NUM_OBSTACLES = 4
);
    logic                     game_on;
    logic                     menu_on;
    logic                     collision;
    logic [NUM_OBSTACLES-1:0] done_in;
    logic [3:0]               selected;
    logic                     play_selected;
    logic                     done_control;
    logic [4:0]               round;
    logic                     game_over;
    logic                     game_won;

    modport master (
        output game_on, menu_on, collision, done_in,
        input  selected, play_selected, done_control, round, game_over, game_won
    );

    modport slave (
        input  game_on, menu_on, collision, done_in,
        output selected, play_selected, done_control, round, game_over, game_won
    );
endinterface

// File: rtl/obstacle_scheduler_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced only when step is high.
module obstacle_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-level obstacle sequencer: pick a code, launch it, wait for done,
// collision or watchdog, then gap and count rounds up to a win.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_OBSTACLES  = 4,
    parameter bit          RANDOM         = 1'b1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned GAP_CYCLES     = CLK_FREQ_HZ / 2,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ * 4,
    parameter int unsigned ROUNDS_TO_WIN  = 16
) (
    input logic                 pclk,
    input logic                 rst_n,
    obstacle_scheduler_if.slave bus
);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d, timer_inc;
    logic [ROUND_W-1:0]  round_q, round_d, round_inc;
    logic [CODE_W-1:0]   cur_q, cur_d, last_q, last_d, cand;
    logic [CODE_W-1:0]   sel_q, sel_d;
    logic                play_q, play_d, dc_q, dc_d, over_q, over_d, won_q, won_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                lfsr_step;
    logic [15:0]         done_w;
    logic                lfsr_unused;

    obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .pclk  (pclk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:4];
    assign done_w      = 16'(bus.done_in);
    assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
    assign round_inc   = round_q + ROUND_W'(1);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            round_q <= '0;
            cur_q   <= '0;
            last_q  <= NO_OBSTACLE;
            sel_q   <= NO_OBSTACLE;
            play_q  <= 1'b0;
            dc_q    <= 1'b1;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            round_q <= round_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            play_q  <= play_d;
            dc_q    <= dc_d;
            over_q  <= over_d;
            won_q   <= won_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with state_q
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        round_d   = round_q;
        cur_d     = cur_q;
        last_d    = last_q;
        lfsr_step = 1'b0;
        cand      = RANDOM ? lfsr_q[3:0] : next_code(last_q, NUM_OBSTACLES);

        case (state_q)
            ST_IDLE: begin
                if (bus.game_on && !bus.menu_on) state_d = ST_PICK;
            end
            ST_PICK: begin
                lfsr_step = 1'b1;
                if (32'(cand) < NUM_OBSTACLES) begin
                    if (cand == last_q && NUM_OBSTACLES > 1) cur_d = next_code(cand, NUM_OBSTACLES);
                    else                                     cur_d = cand;
                    last_d  = cur_d;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.menu_on || !bus.game_on) begin
                    state_d = ST_IDLE;
                end else if (bus.collision) begin
                    state_d = ST_OVER;
                end else if (done_w[cur_q]) begin
                    round_d = round_inc;
                    timer_d = '0;
                    state_d = (round_inc == ROUND_W'(ROUNDS_TO_WIN)) ? ST_WIN : ST_GAP;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_OVER;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_GAP: begin
                if (bus.menu_on || !bus.game_on)                   state_d = ST_IDLE;
                else if (timer_q == TIMER_W'(GAP_CYCLES - 1))      state_d = ST_PICK;
                else                                               timer_d = timer_inc;
            end
            ST_OVER, ST_WIN: begin
                if (bus.menu_on) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) round_d = '0;

        sel_d  = (state_d == ST_LAUNCH || state_d == ST_WAIT) ? cur_d : NO_OBSTACLE;
        play_d = (state_d == ST_LAUNCH || state_d == ST_WAIT || state_d == ST_GAP);
        dc_d   = (state_d != ST_WAIT);
        over_d = (state_d == ST_OVER);
        won_d  = (state_d == ST_WIN);
    end

    assign bus.selected      = sel_q;
    assign bus.play_selected = play_q;
    assign bus.done_control  = dc_q;
    assign bus.round         = round_q;
    assign bus.game_over     = over_q;
    assign bus.game_won      = won_q;

endmodule
